dma_channel_scheduler: RTL and testbench

Multi-channel scheduler in front of the single-word DMA engine. It arbitrates round-robin among NUM_CH requesters, latches the winner's descriptor (source, destination, length), and sequences the engine one word at a time. It issues start pulses with incrementing addresses until the length is exhausted, then reports completion to the owning channel.

---
 rtl/dma_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/dma_channel_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA scheduler and the single-word engine:
// scheduler state encoding and default address/length widths.
package dma_pkg;

    localparam int DMA_AW = 4;
    localparam int DMA_LW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CMPL  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps, returning a one-hot grant and the winner's index.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [2:0]        ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [2:0]        idx,
    output logic              valid
);

    logic [NUM_CH-1:0] mask_hi;
    logic [NUM_CH-1:0] req_hi;
    logic [NUM_CH-1:0] req_sel;

    // Channels above the pointer take priority; otherwise wrap to the lowest.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign mask_hi[gi] = (3'(gi) > ptr);
    end

    assign req_hi  = req & mask_hi;
    assign req_sel = (|req_hi) ? req_hi : req;
    assign valid   = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_sel[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = 3'(i);
            end
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Round-robin multi-channel front end for the single-word DMA engine.
// Optional sticky completion status and interrupt built with DMA_SCHED_IRQ_EN.
module dma_channel_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AW     = DMA_AW,
    parameter int LW     = DMA_LW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*AW-1:0] ch_src,
    input  logic [NUM_CH*AW-1:0] ch_dst,
    input  logic [NUM_CH*LW-1:0] ch_len,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 busy,
    output logic [2:0]           active_ch,
    output logic                 dma_start,
    output logic [AW-1:0]        dma_src,
    output logic [AW-1:0]        dma_dst,
    input  logic                 dma_done
`ifdef DMA_SCHED_IRQ_EN
    ,
    input  logic [NUM_CH-1:0]    irq_mask,
    input  logic [NUM_CH-1:0]    irq_clr,
    output logic [NUM_CH-1:0]    irq_status,
    output logic                 irq
`endif
);

    localparam int MAX_CH = 8;

    logic [1:0]        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        active_q, active_d;
    logic [AW-1:0]     src_q, src_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [NUM_CH-1:0] ack_q, ack_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [2:0]        arb_idx;
    logic              arb_valid;

    // Padded to 8 entries so the 3-bit winner index selects without truncation.
    logic [AW-1:0] src_arr [MAX_CH];
    logic [AW-1:0] dst_arr [MAX_CH];
    logic [LW-1:0] len_arr [MAX_CH];

    for (genvar gi = 0; gi < MAX_CH; gi++) begin : g_unpack
        if (gi < NUM_CH) begin : g_used
            assign src_arr[gi] = ch_src[gi*AW +: AW];
            assign dst_arr[gi] = ch_dst[gi*AW +: AW];
            assign len_arr[gi] = ch_len[gi*LW +: LW];
        end else begin : g_pad
            assign src_arr[gi] = '0;
            assign dst_arr[gi] = '0;
            assign len_arr[gi] = '0;
        end
    end

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .req  (ch_req),
        .ptr  (ptr_q),
        .grant(arb_grant),
        .idx  (arb_idx),
        .valid(arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        ack_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    ptr_d    = arb_idx;
                    active_d = arb_idx;
                    src_d    = src_arr[arb_idx];
                    dst_d    = dst_arr[arb_idx];
                    rem_d    = len_arr[arb_idx];
                    ack_d    = arb_grant;
                    // A zero-length descriptor completes without touching the engine.
                    state_d  = (len_arr[arb_idx] == '0) ? ST_CMPL : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dma_done) begin
                    rem_d   = rem_q - 1'b1;
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    state_d = (rem_q == LW'(1)) ? ST_CMPL : ST_ISSUE;
                end
            end
            ST_CMPL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 3'(NUM_CH - 1);
            active_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            ack_q    <= ack_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_done
        assign ch_done[gi] = (state_q == ST_CMPL) && (active_q == 3'(gi));
    end

    assign ch_ack    = ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign active_ch = active_q;
    assign dma_start = (state_q == ST_ISSUE);
    assign dma_src   = src_q;
    assign dma_dst   = dst_q;

`ifdef DMA_SCHED_IRQ_EN
    logic [NUM_CH-1:0] irq_status_q, irq_status_d;
    logic              irq_q, irq_d;

    // A completion in the same cycle as a clear leaves the flag set.
    always_comb begin
        irq_status_d = (irq_status_q & ~irq_clr) | ch_done;
        irq_d        = |(irq_status_q & irq_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
        end
    end

    assign irq_status = irq_status_q;
    assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler: directed scenarios plus random
// multi-channel traffic, checked against a transaction-level timing model.
module tb_dma_channel_scheduler;

    localparam int NUM_CH = 4;
    localparam int AW     = 4;
    localparam int LW     = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*AW-1:0] ch_src;
    logic [NUM_CH*AW-1:0] ch_dst;
    logic [NUM_CH*LW-1:0] ch_len;
    logic [NUM_CH-1:0]    ch_ack;
    logic [NUM_CH-1:0]    ch_done;
    logic                 busy;
    logic [2:0]           active_ch;
    logic                 dma_start;
    logic [AW-1:0]        dma_src;
    logic [AW-1:0]        dma_dst;
    logic                 dma_done;
`ifdef DMA_SCHED_IRQ_EN
    logic [NUM_CH-1:0]    irq_mask;
    logic [NUM_CH-1:0]    irq_clr;
    logic [NUM_CH-1:0]    irq_status;
    logic                 irq;
`endif

    dma_channel_scheduler #(
        .NUM_CH(NUM_CH),
        .AW    (AW),
        .LW    (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_req    (ch_req),
        .ch_src    (ch_src),
        .ch_dst    (ch_dst),
        .ch_len    (ch_len),
        .ch_ack    (ch_ack),
        .ch_done   (ch_done),
        .busy      (busy),
        .active_ch (active_ch),
        .dma_start (dma_start),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst),
        .dma_done  (dma_done)
`ifdef DMA_SCHED_IRQ_EN
        ,
        .irq_mask  (irq_mask),
        .irq_clr   (irq_clr),
        .irq_status(irq_status),
        .irq       (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-transfer event times derived from the grant cycle.
    int mcyc        = 0;
    int mptr        = NUM_CH - 1;
    int idle_from   = 0;
    int done_cyc    = -1;
    int next_start  = 0;
    int starts_left = 0;
    int eng_done_at = -1;
    int cur_ch      = 0;
    logic [AW-1:0]        exp_src, exp_dst;
    logic [NUM_CH-1:0]    prev_req = '0;
    logic [NUM_CH*AW-1:0] prev_src = '0;
    logic [NUM_CH*AW-1:0] prev_dst = '0;
    logic [NUM_CH*LW-1:0] prev_len = '0;
    int         grants[$];
    logic [7:0] start_log[$];
    bit hold_mode = 1'b0;
    bit spur_en   = 1'b0;
    logic [NUM_CH-1:0] m_status = '0;
    logic              m_irq    = 1'b0;
    bit                clr_arm  = 1'b0;
    bit                rand_clr = 1'b0;
    logic [NUM_CH-1:0] clr_once = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, mcyc);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_CH-1:0] req, input int ptr);
        for (int k = 1; k <= NUM_CH; k++) begin
            int i;
            i = (ptr + k) % NUM_CH;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] all_outs();
`ifdef DMA_SCHED_IRQ_EN
        return 32'({ch_ack, ch_done, busy, active_ch, dma_start, dma_src, dma_dst, irq_status, irq});
`else
        return 32'({ch_ack, ch_done, busy, active_ch, dma_start, dma_src, dma_dst});
`endif
    endfunction

    function automatic logic [31:0] start_at(input int k);
        if (k < start_log.size()) return 32'(start_log[k]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] grant_at(input int k);
        if (k < grants.size()) return 32'(grants[k]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic monitor();
        int w;
        logic [NUM_CH-1:0] exp_ack, exp_done;
        mcyc++;
        if (!rst_n) begin
            check_eq("reset_outputs", all_outs(), 32'd0);
            mptr        = NUM_CH - 1;
            idle_from   = 0;
            done_cyc    = -1;
            starts_left = 0;
            eng_done_at = -1;
            prev_req    = '0;
            m_status    = '0;
            m_irq       = 1'b0;
            return;
        end
        exp_ack = '0;
        w       = -1;
        if ((mcyc - 1) >= idle_from && prev_req != '0) begin
            w       = rr_pick(prev_req, mptr);
            exp_ack = NUM_CH'(1) << w;
        end
        check_eq("ch_ack", 32'(ch_ack), 32'(exp_ack));
        if (w >= 0) begin
            mptr        = w;
            cur_ch      = w;
            grants.push_back(w);
            starts_left = int'(prev_len[w*LW +: LW]);
            next_start  = mcyc;
            exp_src     = prev_src[w*AW +: AW];
            exp_dst     = prev_dst[w*AW +: AW];
            done_cyc    = mcyc + 4 * starts_left;
            idle_from   = done_cyc + 1;
            check_eq("active_ch", 32'(active_ch), 32'(w));
            $display("grant ch%0d src=%0h dst=%0h len=%0d cycle=%0d",
                     w, exp_src, exp_dst, starts_left, mcyc);
        end
        if (starts_left > 0 && mcyc == next_start) begin
            check_eq("dma_start", 32'(dma_start), 32'd1);
            check_eq("dma_src", 32'(dma_src), 32'(exp_src));
            check_eq("dma_dst", 32'(dma_dst), 32'(exp_dst));
            exp_src     = exp_src + 1'b1;
            exp_dst     = exp_dst + 1'b1;
            starts_left = starts_left - 1;
            next_start  = next_start + 4;
            eng_done_at = mcyc + 3;
        end else begin
            check_eq("dma_start_idle", 32'(dma_start), 32'd0);
        end
        if (dma_start) start_log.push_back({dma_src, dma_dst});
        exp_done = (mcyc == done_cyc) ? (NUM_CH'(1) << cur_ch) : '0;
        check_eq("ch_done", 32'(ch_done), 32'(exp_done));
        check_eq("busy", 32'(busy), 32'(mcyc < idle_from));
`ifdef DMA_SCHED_IRQ_EN
        check_eq("irq_status", 32'(irq_status), 32'(m_status));
        check_eq("irq", 32'(irq), 32'(m_irq));
        m_irq    = |(m_status & irq_mask);
        m_status = (m_status & ~irq_clr) | exp_done;
`endif
        prev_req = ch_req;
        prev_src = ch_src;
        prev_dst = ch_dst;
        prev_len = ch_len;
    endtask

    // Requesters drop req on ack; the engine answers 3 cycles after each start.
    task automatic drive();
        if (!hold_mode) ch_req = ch_req & ~ch_ack;
        dma_done = (eng_done_at == mcyc + 1) ||
                   (spur_en && (mcyc + 1) >= idle_from && $urandom_range(0, 3) == 0);
`ifdef DMA_SCHED_IRQ_EN
        irq_clr  = clr_once
                 | ((clr_arm && done_cyc == mcyc + 1) ? NUM_CH'(2) : '0)
                 | (rand_clr ? NUM_CH'($urandom & $urandom & $urandom) : '0);
        clr_once = '0;
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_desc(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] l);
        ch_src[i*AW +: AW] = s;
        ch_dst[i*AW +: AW] = d;
        ch_len[i*LW +: LW] = l;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            cycle();
            n++;
            done = (ch_req == '0) && (prev_req == '0) && (mcyc >= idle_from);
        end
        check_eq("wait_idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_grant(input int target, input int maxc);
        int n;
        n = 0;
        while (grants.size() < target && n < maxc) begin
            cycle();
            n++;
        end
        check_eq("wait_grant_timeout", 32'(grants.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int g0;
        rst_n    = 1'b0;
        ch_req   = '0;
        ch_src   = '0;
        ch_dst   = '0;
        ch_len   = '0;
        dma_done = 1'b0;
`ifdef DMA_SCHED_IRQ_EN
        irq_mask = '0;
        irq_clr  = '0;
`endif
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Single word on ch1
        set_desc(1, 4'h2, 4'h8, 4'd1);
        ch_req[1] = 1'b1;
        n0 = start_log.size();
        wait_idle(40);
        check_eq("single_starts", 32'(start_log.size() - n0), 32'd1);
        check_eq("single_addr", start_at(n0), 32'h28);

        // Multi-word with address wrap on ch0
        set_desc(0, 4'hE, 4'h3, 4'd3);
        ch_req[0] = 1'b1;
        n0 = start_log.size();
        wait_idle(80);
        check_eq("wrap_starts", 32'(start_log.size() - n0), 32'd3);
        check_eq("wrap_addr0", start_at(n0), 32'hE3);
        check_eq("wrap_addr1", start_at(n0 + 1), 32'hF4);
        check_eq("wrap_addr2", start_at(n0 + 2), 32'h05);

        // Zero length on ch2
        set_desc(2, 4'h7, 4'h7, 4'd0);
        ch_req[2] = 1'b1;
        n0 = start_log.size();
        wait_idle(20);
        check_eq("zero_len_starts", 32'(start_log.size() - n0), 32'd0);

        // Round-robin with every request held
        do_reset();
        hold_mode = 1'b1;
        for (int i = 0; i < NUM_CH; i++) set_desc(i, 4'($urandom), 4'($urandom), 4'd1);
        ch_req = '1;
        g0 = grants.size();
        wait_grant(g0 + 5, 200);
        for (int k = 0; k < 5; k++) check_eq("rr_order", grant_at(g0 + k), 32'(k % NUM_CH));
        hold_mode = 1'b0;
        ch_req    = '0;
        wait_idle(60);

        // Reset during WAIT of a len=4 transfer
        set_desc(2, 4'h5, 4'h9, 4'd4);
        ch_req[2] = 1'b1;
        g0 = grants.size();
        wait_grant(g0 + 1, 20);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", all_outs(), 32'd0);
        for (int i = 0; i < NUM_CH; i++) set_desc(i, 4'($urandom), 4'($urandom), 4'd1);
        ch_req = '1;
        cycle();
        cycle();
        rst_n = 1'b1;
        g0 = grants.size();
        wait_grant(g0 + 1, 20);
        check_eq("post_reset_grant", grant_at(g0), 32'd0);
        wait_idle(100);

`ifdef DMA_SCHED_IRQ_EN
        // Sticky status, masked irq, and set-beats-clear
        irq_mask = 4'b0010;
        clr_once = '1;
        cycle();
        set_desc(1, 4'h1, 4'h1, 4'd1);
        ch_req[1] = 1'b1;
        wait_idle(40);
        check_eq("irq_status_set", 32'(irq_status[1]), 32'd1);
        check_eq("irq_raised", 32'(irq), 32'd1);
        clr_arm = 1'b1;
        set_desc(1, 4'h3, 4'h4, 4'd1);
        ch_req[1] = 1'b1;
        wait_idle(40);
        clr_arm = 1'b0;
        check_eq("irq_set_beats_clr", 32'(irq_status[1]), 32'd1);
        clr_once = 4'b0010;
        cycle();
        cycle();
        check_eq("irq_status_cleared", 32'(irq_status[1]), 32'd0);
        rand_clr = 1'b1;
`endif

        // Random multi-channel traffic with spurious engine pulses while idle
        spur_en = 1'b1;
        for (int t = 0; t < 2500; t++) begin
            cycle();
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_req[i] && $urandom_range(0, 5) == 0) begin
                    set_desc(i, 4'($urandom), 4'($urandom),
                             ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
                    ch_req[i] = 1'b1;
                end
            end
`ifdef DMA_SCHED_IRQ_EN
            if (t % 64 == 0) irq_mask = NUM_CH'($urandom);
`endif
        end
        spur_en = 1'b0;
`ifdef DMA_SCHED_IRQ_EN
        rand_clr = 1'b0;
`endif
        wait_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
